// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter datapath and its output buffer.
package iir_pkg;

    // Default sample width of the filter datapath
    localparam int NB_DEFAULT = 12;

    // Width of the optional dropped-sample counter
    localparam int DROPCNT_W = 16;

    // One filtered sample, two's complement
    typedef logic signed [NB_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/iir_fifo_mem.sv
// DEPTH x NB register file: one synchronous write port, one asynchronous
// read port so the buffer head falls through to the output in the same cycle.
module iir_fifo_mem #(
    parameter int  NB    = 12,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [NB-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [NB-1:0] rdata
);

    logic [NB-1:0] words [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [NB-1:0] word_reg;

            // Each word loads only when it is the addressed write target
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rdata = words[raddr];

endmodule

// File: rtl/iir_out_fifo.sv
// Output buffer behind iir_filter: captures every vIn-qualified sample into a
// circular buffer and replays it on a valid/ready stream. The filter cannot
// be stalled, so a sample arriving into a full buffer with no pop is dropped
// and flagged on the sticky ovf output.
// Optional feature: define IIR_FIFO_DROPCNT_EN to add a saturating 16-bit
// drop_cnt output counting dropped samples.
module iir_out_fifo
    import iir_pkg::*;
#(
    parameter int NB    = NB_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vIn,
    input  logic [NB-1:0]              dIn,
    input  logic                       rdy,
    input  logic                       clr_ovf,
    output logic [NB-1:0]              dOut,
    output logic                       vOut,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       ovf
`ifdef IIR_FIFO_DROPCNT_EN
    ,
    output logic [DROPCNT_W-1:0]       drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;
    logic          ovf_reg;

    logic pop;
    logic push;
    logic drop;
    logic mem_we;

    // Occupancy-derived status; EMPTY/PARTIAL/FULL are implicit in level_reg
    assign vOut  = (level_reg != '0);
    assign full  = (level_reg == LW'(DEPTH));
    assign level = level_reg;
    assign ovf   = ovf_reg;

    // A pop frees the slot the incoming sample needs, so full+pop still accepts
    assign pop  = vOut & rdy;
    assign push = vIn & (~full | pop);
    assign drop = vIn & full & ~pop;

    // Samples arriving during reset are discarded
    assign mem_we = push & ~rst;

    iir_fifo_mem #(
        .NB    (NB),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata (dIn),
        .raddr (rd_ptr_reg),
        .rdata (dOut)
    );

    // Occupancy moves only when exactly one of push/pop happens
    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
        end
    end

    // Sticky overflow flag; a new drop overrides a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (drop) begin
            ovf_reg <= 1'b1;
        end else if (clr_ovf) begin
            ovf_reg <= 1'b0;
        end
    end

`ifdef IIR_FIFO_DROPCNT_EN
    logic [DROPCNT_W-1:0] drop_cnt_reg;

    // Saturating drop counter; a clear coinciding with a drop restarts at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (clr_ovf) begin
            drop_cnt_reg <= drop ? DROPCNT_W'(1) : '0;
        end else if (drop && (drop_cnt_reg != '1)) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_iir_out_fifo.sv
// Directed bench for iir_out_fifo: fill/drop, full pass-through, streaming,
// mid-operation reset and clear-vs-drop priority.
module tb_iir_out_fifo;
    import iir_pkg::*;

    localparam int NB    = 12;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          vIn;
    logic [NB-1:0] dIn;
    logic          rdy;
    logic          clr_ovf;
    logic [NB-1:0] dOut;
    logic          vOut;
    logic [3:0]    level;
    logic          full;
    logic          ovf;
`ifdef IIR_FIFO_DROPCNT_EN
    logic [15:0]   drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    iir_out_fifo #(
        .NB    (NB),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vIn      (vIn),
        .dIn      (dIn),
        .rdy      (rdy),
        .clr_ovf  (clr_ovf),
        .dOut     (dOut),
        .vOut     (vOut),
        .level    (level),
        .full     (full),
        .ovf      (ovf)
`ifdef IIR_FIFO_DROPCNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Single vIn pulse carrying one sample
    task automatic push1(input logic [NB-1:0] val);
        dIn = val;
        vIn = 1'b1;
        tick();
        vIn = 1'b0;
    endtask

    logic [NB-1:0] fill_vals [8];

    initial begin
        sample_t s;
        rst = 1'b1; vIn = 1'b0; dIn = '0; rdy = 1'b0; clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_vout", vOut, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
`ifdef IIR_FIFO_DROPCNT_EN
        chk("rst_dcnt", drop_cnt, 0);
`endif

        // Three samples with the consumer stalled
        push1(12'h001);
        chk("first_vout", vOut, 1);
        chk("first_dout", dOut, 12'h001);
        push1(12'h7FF);
        push1(12'h800);
        chk("three_level", level, 3);
        chk("three_head", dOut, 12'h001);
        chk("three_ovf", ovf, 0);

        // Fill to 8, then one dropped sample
        fill_vals[0] = 12'h001; fill_vals[1] = 12'h7FF; fill_vals[2] = 12'h800;
        for (int i = 3; i < 8; i++) begin
            fill_vals[i] = 12'h010 + NB'(i);
            push1(fill_vals[i]);
        end
        chk("fill_full", full, 1);
        chk("fill_ovf", ovf, 0);
        push1(12'hABC);
        chk("drop_full", full, 1);
        chk("drop_level", level, 8);
        chk("drop_ovf", ovf, 1);
`ifdef IIR_FIFO_DROPCNT_EN
        chk("drop_dcnt", drop_cnt, 1);
`endif
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_vout", vOut, 1);
            chk("drain_data", dOut, fill_vals[i]);
            tick();
        end
        rdy = 1'b0;
        chk("drain_empty", vOut, 0);
        chk("drain_ovf_sticky", ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", ovf, 0);
`ifdef IIR_FIFO_DROPCNT_EN
        chk("clr_dcnt", drop_cnt, 0);
`endif

        // Full buffer with simultaneous push and pop for 20 cycles
        for (int i = 0; i < 8; i++) push1(12'h100 + NB'(i));
        chk("pp_full", full, 1);
        rdy = 1'b1;
        vIn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            dIn = 12'h108 + NB'(k);
            chk("pp_head", dOut, 12'h100 + 32'(k));
            tick();
            chk("pp_level", level, 8);
            chk("pp_ovf", ovf, 0);
        end
        vIn = 1'b0;
        for (int k = 20; k < 28; k++) begin
            chk("pp_drain", dOut, 12'h100 + 32'(k));
            tick();
        end
        chk("pp_empty", vOut, 0);
        rdy = 1'b0;

        // Streaming 0..99 with consumer always ready
        rdy = 1'b1;
        vIn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            dIn = NB'(i);
            tick();
            chk("st_vout", vOut, 1);
            chk("st_data", dOut, 32'(i));
            chk("st_level_le1", 32'(level <= 4'd1), 1);
        end
        vIn = 1'b0;
        tick();
        chk("st_done_empty", vOut, 0);
        rdy = 1'b0;

        // Mid-operation reset with level 5 and ovf set
        for (int i = 0; i < 8; i++) push1(12'h200 + NB'(i));
        push1(12'hFFF);
        rdy = 1'b1;
        tick(); tick(); tick();
        rdy = 1'b0;
        chk("pre_rst_level", level, 5);
        chk("pre_rst_ovf", ovf, 1);
        rst = 1'b1;
        vIn = 1'b1;
        dIn = 12'h555;
        tick();
        rst = 1'b0;
        vIn = 1'b0;
        chk("mid_rst_vout", vOut, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_ovf", ovf, 0);
        s = 12'h123;
        push1(s);
        chk("post_rst_vout", vOut, 1);
        chk("post_rst_data", dOut, 12'h123);
        chk("post_rst_level", level, 1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("post_rst_empty", vOut, 0);

        // Clear coinciding with a drop: set wins
        for (int i = 0; i < 8; i++) push1(12'h300 + NB'(i));
        clr_ovf = 1'b1;
        push1(12'hDEA);
        clr_ovf = 1'b0;
        chk("clr_vs_drop_ovf", ovf, 1);
`ifdef IIR_FIFO_DROPCNT_EN
        chk("clr_vs_drop_dcnt", drop_cnt, 1);
        push1(12'hDEB);
        chk("second_drop_dcnt", drop_cnt, 2);
`endif
        chk("clr_vs_drop_level", level, 8);
        chk("clr_vs_drop_head", dOut, 12'h300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
